adder_measure_sequencer: RTL and testbench

// Sequences one delay measurement of the wrapped instrumented adder.
// - Drives the adder operands and the active-low ring, extension and output tap selects.
// - Closes the ring for a programmed gate window and counts rising edges of chain_out.
// - Reports the count with a start/busy/done handshake.

---
 rtl/adder_measure_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_adder_measure_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer
// Runs one delay measurement of the instrumented adder. It drives the operands
// and the active-low tap selects, closes the ring for a programmed gate window,
// counts rising edges of the synchronised chain_out and reports the count
// through a start/busy/done handshake.
module adder_measure_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned TIMER_W       = 32,
    parameter int unsigned COUNT_W       = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   cfg_a,
    input  logic [WIDTH-1:0]   cfg_b,
    input  logic [WIDTH-1:0]   cfg_ring_sel,
    input  logic [WIDTH-1:0]   cfg_ext_sel,
    input  logic [WIDTH-1:0]   cfg_out_sel,
    input  logic [TIMER_W-1:0] cfg_window,
    input  logic               chain_out,
    output logic [WIDTH-1:0]   adder_a,
    output logic [WIDTH-1:0]   adder_b,
    output logic [WIDTH-1:0]   ring_sel_n,
    output logic [WIDTH-1:0]   ext_sel_n,
    output logic [WIDTH-1:0]   out_sel_n,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] result,
    output logic               overflow
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SETTLE,
        MEASURE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       ring_q;
    logic [WIDTH-1:0]       ext_q;
    logic [WIDTH-1:0]       out_q;
    logic [TIMER_W-1:0]     window_q;

    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   settle_last;
    logic [TIMER_W-1:0]     timer;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   edge_prev;
    logic                   rise;
    logic [COUNT_W-1:0]     edge_cnt;
    logic [COUNT_W-1:0]     cnt_nxt;
    logic                   ovf_flag;
    logic                   ovf_nxt;

    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign rise        = sync_out & ~edge_prev;

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic; abort takes priority over start and over window expiry
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = (start && !abort) ? SETUP : IDLE;
            SETUP:      state_nxt = abort ? IDLE : SETTLE;
            SETTLE: begin
                if (abort)
                    state_nxt = IDLE;
                else if (settle_last)
                    state_nxt = (window_q == '0) ? DONE : MEASURE;
            end
            MEASURE: begin
                if (abort)
                    state_nxt = IDLE;
                else if (timer == TIMER_W'(1))
                    state_nxt = DONE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        busy = (state == SETUP) || (state == SETTLE) || (state == MEASURE);
        done = (state == DONE);
    end

    // Capture the configuration when a start is accepted
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            ring_q   <= '0;
            ext_q    <= '0;
            out_q    <= '0;
            window_q <= '0;
        end else if (state_nxt == SETUP) begin
            a_q      <= cfg_a;
            b_q      <= cfg_b;
            ring_q   <= cfg_ring_sel;
            ext_q    <= cfg_ext_sel;
            out_q    <= cfg_out_sel;
            window_q <= cfg_window;
        end
    end

    // Settle-cycle counter and gate-window down-counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            settle_cnt <= '0;
            timer      <= '0;
        end else begin
            settle_cnt <= (state == SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
            if (state == SETTLE)
                timer <= window_q;
            else if (state == MEASURE)
                timer <= timer - TIMER_W'(1);
        end
    end

    // Adder operands and tap selects; the ring is closed only for MEASURE cycles
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            adder_a    <= '0;
            adder_b    <= '0;
            ring_sel_n <= '1;
            ext_sel_n  <= '1;
            out_sel_n  <= '1;
        end else if (state_nxt == IDLE || state_nxt == DONE) begin
            ring_sel_n <= '1;
            ext_sel_n  <= '1;
            out_sel_n  <= '1;
        end else if (state == SETUP) begin
            adder_a    <= a_q;
            adder_b    <= b_q;
            ext_sel_n  <= ~ext_q;
            out_sel_n  <= ~out_q;
        end else if (state == SETTLE && state_nxt == MEASURE) begin
            ring_sel_n <= ~ring_q;
        end
    end

    // chain_out synchroniser and edge-detect history
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q    <= '0;
            edge_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], chain_out};
            edge_prev <= sync_out;
        end
    end

    // Saturating increment of the edge count
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf_flag;
        if (rise) begin
            if (edge_cnt == '1) ovf_nxt = 1'b1;
            else                cnt_nxt = edge_cnt + COUNT_W'(1);
        end
    end

    // Edge counter: cleared while settling, advanced during the gate window
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (state == SETTLE) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (state == MEASURE) begin
            edge_cnt <= cnt_nxt;
            ovf_flag <= ovf_nxt;
        end
    end

    // Result publish on entry to DONE, so it is valid alongside the done pulse
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (state_nxt == DONE) begin
            result   <= (state == MEASURE) ? cnt_nxt : '0;
            overflow <= (state == MEASURE) ? ovf_nxt : 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer
// Two instances (32-bit and 4-bit edge counter) share all inputs. chain_out is
// played from a pre-generated level table, so the expected edge count of a run
// is known the moment its start is issued and is queued for the done monitor.
module tb_adder_measure_sequencer;

    localparam int S     = 4;
    localparam int SYNC  = 2;
    localparam int LVL_N = 20000;

    typedef struct {
        int          dcyc;
        logic [31:0] r0;
        logic        ov0;
        logic [3:0]  r1;
        logic        ov1;
    } exp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_a, cfg_b, cfg_ring_sel, cfg_ext_sel, cfg_out_sel, cfg_window;
    logic        chain_out;

    logic [31:0] u0_adder_a, u0_adder_b, u0_ring_sel_n, u0_ext_sel_n, u0_out_sel_n, u0_result;
    logic        u0_busy, u0_done, u0_overflow;
    logic [31:0] u1_adder_a, u1_adder_b, u1_ring_sel_n, u1_ext_sel_n, u1_out_sel_n;
    logic [3:0]  u1_result;
    logic        u1_busy, u1_done, u1_overflow;

    int   vectors = 0;
    int   miscompares = 0;
    int   edge_n = 0;
    bit   lvl [LVL_N];
    exp_t sbq [$];

    logic [31:0] last_r0 = '0;
    logic        last_ov0 = 1'b0;
    logic [3:0]  last_r1 = '0;
    logic        last_ov1 = 1'b0;

    adder_measure_sequencer #(
        .WIDTH(32), .TIMER_W(32), .COUNT_W(32), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC)
    ) u0 (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .abort(abort),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ring_sel(cfg_ring_sel),
        .cfg_ext_sel(cfg_ext_sel), .cfg_out_sel(cfg_out_sel), .cfg_window(cfg_window),
        .chain_out(chain_out), .adder_a(u0_adder_a), .adder_b(u0_adder_b),
        .ring_sel_n(u0_ring_sel_n), .ext_sel_n(u0_ext_sel_n), .out_sel_n(u0_out_sel_n),
        .busy(u0_busy), .done(u0_done), .result(u0_result), .overflow(u0_overflow)
    );

    adder_measure_sequencer #(
        .WIDTH(32), .TIMER_W(32), .COUNT_W(4), .SETTLE_CYCLES(S), .SYNC_STAGES(SYNC)
    ) u1 (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .start(start), .abort(abort),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ring_sel(cfg_ring_sel),
        .cfg_ext_sel(cfg_ext_sel), .cfg_out_sel(cfg_out_sel), .cfg_window(cfg_window),
        .chain_out(chain_out), .adder_a(u1_adder_a), .adder_b(u1_adder_b),
        .ring_sel_n(u1_ring_sel_n), .ext_sel_n(u1_ext_sel_n), .out_sel_n(u1_out_sel_n),
        .busy(u1_busy), .done(u1_done), .result(u1_result), .overflow(u1_overflow)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // edge_n = number of rising clock edges so far; cycle k lies between edges k and k+1
    always @(posedge wb_clk_i) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Rising edges of chain_out sampled at clock edges lo..hi
    function automatic int count_rises(input int lo, input int hi);
        int n = 0;
        for (int p = lo; p <= hi; p++)
            if (lvl[p] && !lvl[p-1]) n++;
        return n;
    endfunction

    task automatic fill_periodic(input int h);
        for (int k = edge_n + 3; k < edge_n + 400; k++)
            lvl[k] = ((k / h) % 2) == 1;
    endtask

    // chain_out player: the level driven now is sampled at the next rising edge
    initial begin
        chain_out = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            chain_out = lvl[edge_n + 1];
        end
    end

    // Done monitor: every done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_n === 1'b1 && (u0_done === 1'b1 || u1_done === 1'b1)) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", edge_n);
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", edge_n, e.dcyc);
                    check("done_u0", u0_done, 1'b1);
                    check("done_u1", u1_done, 1'b1);
                    check("result_u0", u0_result, e.r0);
                    check("overflow_u0", u0_overflow, e.ov0);
                    check("result_u1", u1_result, e.r1);
                    check("overflow_u1", u1_overflow, e.ov1);
                    check("busy_in_done", u0_busy, 1'b0);
                    check("ring_open_in_done", u0_ring_sel_n, 32'hFFFF_FFFF);
                end
            end
        end
    end

    // One measurement; called at a falling edge, returns at the falling edge of
    // the DONE cycle (or a few cycles after an abort). ab/sb are cycle offsets
    // from the SETUP cycle for abort/stray start (-1 = none); ovr >= 0 forces
    // the expected edge count instead of deriving it from the level table.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ring,
                       input logic [31:0] ext, input logic [31:0] outs, input int win,
                       input int ab, input int sb, input int ovr);
        int          e0, dcyc, end_c, n;
        exp_t        e;
        logic [31:0] exp_ring, n_ext, n_out;
        n_ext = ~ext;
        n_out = ~outs;
        cfg_a = a; cfg_b = b; cfg_ring_sel = ring; cfg_ext_sel = ext;
        cfg_out_sel = outs; cfg_window = 32'(win);
        start = 1'b1;
        abort = 1'b0;
        e0   = edge_n + 1;
        dcyc = e0 + S + win + 1;
        e    = '{default: '0};
        if (ab < 0) begin
            n = (ovr >= 0) ? ovr : count_rises(e0 + S + 2 - SYNC, e0 + S + win + 1 - SYNC);
            e.dcyc = dcyc;
            e.r0   = 32'(n);
            e.ov0  = 1'b0;
            e.r1   = (n > 15) ? 4'hF : 4'(n);
            e.ov1  = (n > 15);
            sbq.push_back(e);
            end_c = dcyc;
        end else begin
            end_c = e0 + ab;
        end
        for (int c = e0; c <= end_c; c++) begin
            @(negedge wb_clk_i);
            start = (sb >= 0) && (c == e0 + sb);
            abort = (ab >= 0) && (c == end_c);
            cfg_a = $urandom; cfg_b = $urandom; cfg_ring_sel = $urandom;
            cfg_ext_sel = $urandom; cfg_out_sel = $urandom;
            cfg_window = $urandom_range(0, 200);
            if (c < dcyc) begin
                exp_ring = ((win > 0) && (c >= e0 + S + 1) && (c <= e0 + S + win)) ? ~ring : 32'hFFFF_FFFF;
                check("busy_u0", u0_busy, c <= e0 + S + win);
                check("busy_u1", u1_busy, c <= e0 + S + win);
                check("ring_sel_n", u0_ring_sel_n, exp_ring);
                if (c > e0) begin
                    check("adder_a", u0_adder_a, a);
                    check("adder_b", u0_adder_b, b);
                    check("ext_sel_n", u0_ext_sel_n, n_ext);
                    check("out_sel_n", u0_out_sel_n, n_out);
                end
            end
        end
        if (ab >= 0) begin
            @(negedge wb_clk_i);
            start = 1'b0;
            abort = 1'b0;
            check("abort_busy_u0", u0_busy, 1'b0);
            check("abort_busy_u1", u1_busy, 1'b0);
            check("abort_ring", u0_ring_sel_n, 32'hFFFF_FFFF);
            check("abort_ext", u0_ext_sel_n, 32'hFFFF_FFFF);
            check("abort_out", u0_out_sel_n, 32'hFFFF_FFFF);
            check("abort_result_u0", u0_result, last_r0);
            check("abort_overflow_u0", u0_overflow, last_ov0);
            check("abort_result_u1", u1_result, last_r1);
            check("abort_overflow_u1", u1_overflow, last_ov1);
            repeat (3) @(negedge wb_clk_i);
        end else begin
            #1;
            check("done_seen", sbq.size(), 0);
            sbq.delete();
            last_r0 = e.r0; last_ov0 = e.ov0; last_r1 = e.r1; last_ov1 = e.ov1;
        end
    endtask

    initial begin
        int          k, win, ab, sb, gap;
        bit          v;
        logic [31:0] ring;

        k = 0;
        v = 1'b0;
        while (k < LVL_N) begin
            int rl = $urandom_range(1, 6);
            for (int j = 0; j < rl && k < LVL_N; j++) begin
                lvl[k] = v;
                k++;
            end
            v = !v;
        end

        wb_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0;
        cfg_a = '0; cfg_b = '0; cfg_ring_sel = '0; cfg_ext_sel = '0;
        cfg_out_sel = '0; cfg_window = '0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        repeat (10) @(negedge wb_clk_i);

        check("rst_ring_sel_n", u0_ring_sel_n, 32'hFFFF_FFFF);
        check("rst_ext_sel_n", u0_ext_sel_n, 32'hFFFF_FFFF);
        check("rst_out_sel_n", u0_out_sel_n, 32'hFFFF_FFFF);
        check("rst_busy", u0_busy, 1'b0);
        check("rst_done", u0_done, 1'b0);
        check("rst_result_u0", u0_result, 32'h0);
        check("rst_result_u1", u1_result, 4'h0);
        check("rst_overflow", u0_overflow, 1'b0);
        check("rst_adder_a", u0_adder_a, 32'h0);

        // Zero window: no gate, ring never closed, done six cycles after start
        run(32'd5, 32'd3, 32'h20, 32'h1, 32'h8000_0000, 0, -1, -1, 0);
        repeat (2) @(negedge wb_clk_i);

        // chain_out period 2: 50 edges, 4-bit counter saturates
        fill_periodic(1);
        run(32'd5, 32'd3, 32'h20, 32'h1, 32'h8000_0000, 100, -1, -1, 50);
        repeat (2) @(negedge wb_clk_i);

        // chain_out toggles every 5 clocks: 10 edges in 100 cycles
        fill_periodic(5);
        run(32'd5, 32'd3, 32'h20, 32'h1, 32'h8000_0000, 100, -1, -1, 10);
        repeat (2) @(negedge wb_clk_i);

        // Abort 20 cycles into MEASURE keeps the previous result
        fill_periodic(5);
        run(32'd7, 32'd9, 32'h20, 32'h2, 32'h4, 100, S + 1 + 20, -1, -1);

        // Stray start while busy, then a new start in the DONE cycle
        fill_periodic(5);
        run(32'd5, 32'd3, 32'h20, 32'h1, 32'h8000_0000, 100, -1, 30, 10);
        run(32'hDEAD_BEEF, 32'h1234_5678, 32'h1, 32'hF0, 32'h0F, 20, -1, -1, -1);
        repeat (2) @(negedge wb_clk_i);

        // start and abort together in IDLE: abort wins
        cfg_window = 32'd10;
        start = 1'b1; abort = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("start_abort_idle_busy", u0_busy, 1'b0);
            @(negedge wb_clk_i);
        end

        for (int i = 0; i < 25; i++) begin
            win  = $urandom_range(0, 150);
            ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, S + win) : -1;
            sb   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S + win) : -1;
            ring = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
            run($urandom, $urandom, ring, $urandom, $urandom, win, ab, sb, -1);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge wb_clk_i);
        end

        // Reset mid-measurement opens the ring immediately
        repeat (2) @(negedge wb_clk_i);
        cfg_a = 32'd11; cfg_b = 32'd22; cfg_ring_sel = 32'h100; cfg_ext_sel = 32'h3;
        cfg_out_sel = 32'h5; cfg_window = 32'd100;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (12) @(negedge wb_clk_i);
        check("ring_closed_pre_reset", u0_ring_sel_n, 32'hFFFF_FEFF);
        #2 wb_rst_n = 1'b0;
        #1;
        check("midrst_ring", u0_ring_sel_n, 32'hFFFF_FFFF);
        check("midrst_busy", u0_busy, 1'b0);
        check("midrst_result", u0_result, 32'h0);
        check("midrst_adder_a", u0_adder_a, 32'h0);
        check("midrst_ext", u0_ext_sel_n, 32'hFFFF_FFFF);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("post_rst_busy", u0_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
